// File: rtl/synth_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : synth_voice_mixer
// Summary  : Time-multiplexed phase-accumulator voices, summed and saturated
//            into one 17-bit sample per DIV-cycle frame for the I2S feeder.
// Revision : 1.0 - initial release
// ============================================================================
module synth_voice_mixer #(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 24,
  parameter int DIV     = 1024
) (
  input  logic               clk48m,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [1:0]         cfg_wave,
  input  logic [3:0]         cfg_vol,
  input  logic               cfg_sync,
  output logic [16:0]        signal,
  output logic               sample_strobe
);

  localparam int c_CNT_W = $clog2(DIV);
  localparam int c_ACC_W = 18 + $clog2(VOICES);
  localparam logic [1:0] c_WAVE_SQR = 2'd1;
  localparam logic [1:0] c_WAVE_SAW = 2'd2;
  localparam logic [1:0] c_WAVE_TRI = 2'd3;
  localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'(32767);
  localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = c_ACC_W'(-32768);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_OUT = 2'd2} state_t;

  state_t                     r_state, w_state_nxt;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [2:0]                 r_vi;
  logic signed [c_ACC_W-1:0]  r_acc;
  logic [PHASE_W-1:0]         r_phase [VOICES];
  logic [PHASE_W-1:0]         r_inc   [VOICES];
  logic [1:0]                 r_wave  [VOICES];
  logic [3:0]                 r_vol   [VOICES];

  logic [VOICES-1:0]          w_wr, w_active;
  logic [15:0]                w_p;
  logic [1:0]                 w_cur_wave;
  logic [3:0]                 w_cur_vol;
  logic [14:0]                w_tri;
  logic signed [15:0]         w_wave;
  logic signed [20:0]         w_prod;
  logic signed [16:0]         w_scaled;
  logic signed [c_ACC_W-1:0]  w_acc_sum;
  logic [15:0]                w_sat;
  logic                       w_last;

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst)                               r_cnt <= '0;
    else if (r_cnt == c_CNT_W'(DIV - 1))   r_cnt <= '0;
    else                                   r_cnt <= r_cnt + c_CNT_W'(1);
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_dec
    assign w_wr[gi]     = cfg_we && (cfg_voice == 3'(gi));
    assign w_active[gi] = (r_state == S_ACCUM) && (r_vi == 3'(gi));
  end

  // A sync write overrides the increment of a voice processed in the same cycle.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
        r_wave[i]  <= '0;
        r_vol[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (w_wr[i]) begin
          r_inc[i]  <= cfg_inc;
          r_wave[i] <= cfg_wave;
          r_vol[i]  <= cfg_vol;
        end
        if (w_wr[i] && cfg_sync) r_phase[i] <= '0;
        else if (w_active[i])    r_phase[i] <= r_phase[i] + r_inc[i];
      end
    end
  end

  always_comb begin
    w_p        = '0;
    w_cur_wave = '0;
    w_cur_vol  = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (r_vi == 3'(i)) begin
        w_p        = r_phase[i][PHASE_W-1 -: 16];
        w_cur_wave = r_wave[i];
        w_cur_vol  = r_vol[i];
      end
    end
  end

  // Triangle 2*t - 32768 equals {t,0} with the sign bit flipped.
  always_comb begin
    w_tri = w_p[15] ? ~w_p[14:0] : w_p[14:0];
    case (w_cur_wave)
      c_WAVE_SQR: w_wave = w_p[15] ? -16'sd16384 : 16'sd16383;
      c_WAVE_SAW: w_wave = {~w_p[15], w_p[14:0]};
      c_WAVE_TRI: w_wave = {~w_tri[14], w_tri[13:0], 1'b0};
      default:    w_wave = '0;
    endcase
    w_prod    = $signed({{5{w_wave[15]}}, w_wave}) * $signed({16'b0, 1'b0, w_cur_vol});
    w_scaled  = 17'(w_prod >>> 4);
    w_acc_sum = r_acc + {{(c_ACC_W-17){w_scaled[16]}}, w_scaled};
    if (w_acc_sum > c_SAT_MAX)      w_sat = 16'h7FFF;
    else if (w_acc_sum < c_SAT_MIN) w_sat = 16'h8000;
    else                            w_sat = w_acc_sum[15:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE:  if (r_cnt == '0) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (r_vi == 3'(VOICES - 1)) begin
          w_state_nxt = S_OUT;
          w_last      = 1'b1;
        end
      end
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers load on the last voice so strobe and sample appear in OUT.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vi          <= '0;
      r_acc         <= '0;
      signal        <= '0;
      sample_strobe <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      sample_strobe <= w_last;
      if (r_state == S_IDLE) begin
        r_vi  <= '0;
        r_acc <= '0;
      end else if (r_state == S_ACCUM) begin
        r_vi  <= r_vi + 3'd1;
        r_acc <= w_acc_sum;
      end
      if (w_last) signal <= {w_sat[15], w_sat};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synth_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_voice_mixer
// Summary  : Directed and randomized checks of synth_voice_mixer against a
//            frame-level arithmetic model of the voice mixer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synth_voice_mixer;

  localparam int VOICES  = 4;
  localparam int PHASE_W = 24;
  localparam int DIV     = 1024;
  localparam int unsigned PMASK = (1 << PHASE_W) - 1;

  logic               clk48m = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_voice = '0;
  logic [PHASE_W-1:0] cfg_inc = '0;
  logic [1:0]         cfg_wave = '0;
  logic [3:0]         cfg_vol = '0;
  logic               cfg_sync = 1'b0;
  logic [16:0]        signal;
  logic               sample_strobe;

  synth_voice_mixer #(.VOICES(VOICES), .PHASE_W(PHASE_W), .DIV(DIV)) dut (
    .clk48m(clk48m), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc), .cfg_wave(cfg_wave), .cfg_vol(cfg_vol),
    .cfg_sync(cfg_sync), .signal(signal), .sample_strobe(sample_strobe)
  );

  always #5 clk48m = ~clk48m;

  int n_vec = 0;
  int n_err = 0;

  int unsigned m_phase [VOICES];
  int unsigned m_inc   [VOICES];
  int          m_wave  [VOICES];
  int          m_vol   [VOICES];
  int          m_cnt, m_sum, m_signal;
  bit          m_strobe;

  task automatic check(string name, logic [16:0] got, logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int wave_val(int wave, int unsigned phase);
    int p, hi, lo;
    p  = int'((phase >> (PHASE_W - 16)) & 32'hFFFF);
    hi = p / 32768;
    lo = p % 32768;
    case (wave)
      1: return hi ? -16384 : 16383;
      2: return hi ? lo : lo - 32768;
      3: return 2 * (hi ? (32767 - lo) : lo) - 32768;
      default: return 0;
    endcase
  endfunction

  function automatic int scale(int w, int vol);
    int prod;
    prod = w * vol;
    if (prod >= 0) return prod / 16;
    return -((-prod + 15) / 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_phase[i] = 0; m_inc[i] = 0; m_wave[i] = 0; m_vol[i] = 0;
    end
    m_cnt = 0; m_sum = 0; m_signal = 0; m_strobe = 0;
  endtask

  // Frame view: voice v is mixed on frame cycle v+1, sample appears on VOICES+1.
  task automatic model_edge();
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    c = m_cnt;
    m_strobe = 0;
    if (c == 0) m_sum = 0;
    if (c >= 1 && c <= VOICES) begin
      m_sum += scale(wave_val(m_wave[c-1], m_phase[c-1]), m_vol[c-1]);
      m_phase[c-1] = (m_phase[c-1] + m_inc[c-1]) & PMASK;
    end
    if (c == VOICES) begin
      m_strobe = 1;
      m_signal = (m_sum > 32767) ? 32767 : (m_sum < -32768) ? -32768 : m_sum;
    end
    if (cfg_we && int'(cfg_voice) < VOICES) begin
      m_inc[cfg_voice]  = int'(cfg_inc);
      m_wave[cfg_voice] = int'(cfg_wave);
      m_vol[cfg_voice]  = int'(cfg_vol);
      if (cfg_sync) m_phase[cfg_voice] = 0;
    end
    m_cnt = (c == DIV - 1) ? 0 : c + 1;
  endtask

  task automatic step();
    logic [16:0] exp_sig;
    @(posedge clk48m);
    model_edge();
    #1;
    exp_sig = 17'(m_signal);
    check("signal", signal, exp_sig);
    check("strobe", {16'b0, sample_strobe}, {16'b0, m_strobe});
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_strobe && n < 2 * DIV);
    if (!sample_strobe) begin
      n_vec++; n_err++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", n);
    end
  endtask

  task automatic wait_cnt(int target);
    int k = 0;
    while (m_cnt != target && k < 2 * DIV) begin
      step();
      k++;
    end
  endtask

  task automatic cfg_write(int v, int unsigned inc, int wave, int vol, bit sync);
    cfg_we = 1'b1; cfg_voice = 3'(v); cfg_inc = PHASE_W'(inc);
    cfg_wave = 2'(wave); cfg_vol = 4'(vol); cfg_sync = sync;
    step();
    cfg_we = 1'b0; cfg_sync = 1'b0;
  endtask

  task automatic expect_sample(string name, logic [16:0] exp);
    int n;
    wait_strobe(n);
    check(name, signal, exp);
  endtask

  initial begin
    int n;
    model_reset();
    #2;
    check("reset_signal", signal, 17'h0);
    check("reset_strobe", {16'b0, sample_strobe}, 17'h0);
    step(); step();
    rst = 1'b0;

    wait_strobe(n);
    check("first_strobe_delay", 17'(n), 17'(VOICES + 1));
    wait_strobe(n);
    check("strobe_period", 17'(n), 17'(DIV));

    cfg_write(0, 32'h800000, 1, 15, 1);
    expect_sample("square_pos", 17'h03BFF);
    expect_sample("square_neg", 17'h1C400);
    expect_sample("square_pos2", 17'h03BFF);

    cfg_write(0, 0, 2, 15, 1);
    expect_sample("saw_low", 17'h18800);
    expect_sample("saw_low2", 17'h18800);

    for (int v = 0; v < VOICES; v++) cfg_write(v, 0, 1, 15, 1);
    expect_sample("sat_pos", 17'h07FFF);
    for (int v = 0; v < VOICES; v++) cfg_write(v, 32'h800000, 1, 15, 1);
    expect_sample("sat_pos_again", 17'h07FFF);
    expect_sample("sat_neg", 17'h18000);

    for (int v = 1; v < VOICES; v++) cfg_write(v, 0, 0, 0, 0);
    cfg_write(0, 32'h400000, 3, 8, 1);
    expect_sample("tri_0000", 17'h1C000);
    expect_sample("tri_4000", 17'h00000);
    expect_sample("tri_8000", 17'h03FFF);
    wait_strobe(n);

    // Abort a pass while voice 1 is being mixed.
    wait_cnt(2);
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_signal", signal, 17'h0);
    check("abort_strobe", {16'b0, sample_strobe}, 17'h0);
    step();
    rst = 1'b0;
    wait_strobe(n);
    check("post_abort_delay", 17'(n), 17'(VOICES + 1));
    check("post_abort_signal", signal, 17'h0);
    cfg_write(0, 32'h800000, 1, 15, 1);
    expect_sample("resync_pos", 17'h03BFF);

    cfg_write(0, 0, 0, 0, 0);
    wait_cnt(2);
    cfg_write(1, 0, 1, 15, 0);
    expect_sample("late_write_old", 17'h0);
    expect_sample("late_write_new", 17'h03BFF);

    for (int k = 0; k < 12 * DIV; k++) begin
      bit do_wr;
      do_wr = (m_cnt <= VOICES + 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 127) == 0);
      cfg_we    = do_wr;
      cfg_voice = 3'($urandom_range(0, 7));
      cfg_inc   = PHASE_W'($urandom);
      cfg_wave  = 2'($urandom_range(0, 3));
      cfg_vol   = 4'($urandom_range(0, 15));
      cfg_sync  = ($urandom_range(0, 3) == 0);
      step();
    end
    cfg_we = 1'b0;
    cfg_sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
